alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
Writeback stage directly downstream of the 8-bit ALU. It captures the ALU result and flag into a one-entry WB pipeline register, then commits them to a 16x8 register file and a 1-bit flag register. Two combinational read ports with WB bypass feed the ALU A/B operands. The committed/forwarded flag feeds the ALU flagIn. A stall input freezes the stage.

Parameters:
DW, 8, data width (ALU result width)
NREGS, 16, number of architectural registers
AW, 4, register address width, equals clog2(NREGS)
CNTW, 16, retire counter width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  freeze WB register and commit; in_ready=!stall
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage accepts input (combinational, =!stall)
alu_out  input  DW  ALU out
alu_flag  input  1  ALU flag
wr_en  input  1  instruction writes alu_out to register wr_addr
wr_addr  input  AW  destination register
flag_en  input  1  instruction updates flag register
rd_addr_a  input  AW  operand A read address
rd_addr_b  input  AW  operand B read address
rd_data_a  output  DW  operand A (bypassed), to ALU A
rd_data_b  output  DW  operand B (bypassed), to ALU B
flag_fwd  output  1  forwarded flag, to ALU flagIn
flag_q  output  1  committed flag register
retired_cnt  output  CNTW  count of committed entries

Behaviour:
- Reset (async, rst_n=0): all rf entries=0, flag_q=0, wb_valid=0, WB fields=0, retired_cnt=0. Outputs then read 0 and flag_fwd=0. A pending WB entry during reset is dropped with no commit.
- Capture: the rising edge with in_valid=1 and stall=0 loads WB register {valid=1, data=alu_out, flag=alu_flag, we=wr_en, fe=flag_en, addr=wr_addr}. Edge with in_valid=0 and stall=0: wb_valid<=0.
- Commit: the rising edge with wb_valid=1 and stall=0 commits. If we, rf[addr]<=data. If fe, flag_q<=flag. retired_cnt<=retired_cnt+1, wrapping 0xFFFF->0x0000. An entry with we=fe=0 still retires.
- Simultaneous commit and capture on the same edge: the old entry commits and the new entry loads. The ALU result reaches the rf 2 edges after presentation.
- Stall=1: the WB register, rf, flag_q and retired_cnt all hold, and inputs are ignored. Bypass stays active from the held entry.
- Read A/B, combinational: if wb_valid && we && addr==rd_addr, return WB data. Otherwise return rf[rd_addr]. Both ports may hit the same address.
- flag_fwd = (wb_valid && fe) ? WB flag : flag_q.
- No write-enable gating on register 0; all NREGS entries are writable.
- No latches: all combinational paths have full defaults.

Decomposition:
- Shared package `definitions`: DW, AW, NREGS constants, and a packed struct wb_entry_t {valid, we, fe, addr[AW], data[DW], flag}.
- Sub-module reg_file_2r1w: NREGS x DW storage, async reset, 1 sync write port, 2 async read ports. Bypass muxes stay in alu_writeback.

Test Plan:
- Reset then read: rst_n low 2 cycles, release → rd_data_a/b=0x00 for all addresses, flag_fwd=0, retired_cnt=0.
- Basic write/bypass: in_valid=1, wr_en=1, wr_addr=3, alu_out=0x5A, rd_addr_a=3.
  - After edge 1: rd_data_a=0x5A via bypass, rf[3] still 0.
  - After edge 2: rf[3]=0x5A, retired_cnt=1.
- Back-to-back same register: writes 0x11 then 0x22 to r7 on consecutive cycles, rd_addr_a=rd_addr_b=7 → after edge 1 both read 0x11. After edge 2 both read 0x22 (bypass beats rf=0x11). After edge 3 rf[7]=0x22.
- Flag path: flag_en=1, alu_flag=1, wr_en=0 → flag_fwd=1 after edge 1, flag_q=1 after edge 2, no rf change. Next entry with flag_en=0 leaves flag_q=1.
- Stall: WB holds r2=0x80. stall=1 for 3 cycles with in_valid=1, alu_out=0xFF → in_ready=0, rf[2] unchanged, rd_data(r2)=0x80 bypassed, retired_cnt constant. Drop stall → 0x80 commits, then 0xFF enters WB.
- Counter wrap and mid-op reset: preload retired_cnt=0xFFFF via 65535 commits, then one more → 0x0000. Assert rst_n low while wb_valid=1 → pending write never lands, rf=0.

Source files
------------

// File: rtl/definitions.sv
// ============================================================================
// definitions : shared constants and WB pipeline entry type for alu_writeback
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package definitions;

  localparam int DW    = 8;
  localparam int NREGS = 16;
  localparam int AW    = $clog2(NREGS);
  localparam int CNTW  = 16;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          fe;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          flag;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ============================================================================
// reg_file_2r1w : NREGS x DW register file, one sync write, two async reads
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w
  import definitions::*;
#(
  parameter int RF_DW    = 8,
  parameter int RF_NREGS = 16,
  parameter int RF_AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [RF_DW-1:0] wdata,
  input  logic [RF_AW-1:0] raddr_a,
  input  logic [RF_AW-1:0] raddr_b,
  output logic [RF_DW-1:0] rdata_a,
  output logic [RF_DW-1:0] rdata_b
);

  logic [RF_DW-1:0] r_mem [RF_NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_a = r_mem[raddr_a];
  assign rdata_b = r_mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/alu_writeback.sv
// ============================================================================
// alu_writeback : one-entry WB register committing ALU results to rf/flag,
//                 with WB bypass on both operand read ports
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_writeback
  import definitions::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_flag,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            flag_en,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [DW-1:0]   rd_data_a,
  output logic [DW-1:0]   rd_data_b,
  output logic            flag_fwd,
  output logic            flag_q,
  output logic [CNTW-1:0] retired_cnt
);

  wb_entry_t       r_wb;
  logic            r_flag;
  logic [CNTW-1:0] r_cnt;
  logic            w_commit;
  logic [DW-1:0]   w_rf_a;
  logic [DW-1:0]   w_rf_b;

  assign in_ready = !stall;
  assign w_commit = r_wb.valid && !stall;

  // Only valid is cleared on a bubble; the stale payload is masked by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb <= '0;
    end else if (!stall) begin
      if (in_valid) begin
        r_wb.valid <= 1'b1;
        r_wb.we    <= wr_en;
        r_wb.fe    <= flag_en;
        r_wb.addr  <= wr_addr;
        r_wb.data  <= alu_out;
        r_wb.flag  <= alu_flag;
      end else begin
        r_wb.valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else if (w_commit) begin
      if (r_wb.fe) begin
        r_flag <= r_wb.flag;
      end
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  reg_file_2r1w #(
    .RF_DW    (DW),
    .RF_NREGS (NREGS),
    .RF_AW    (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (w_commit && r_wb.we),
    .waddr   (r_wb.addr),
    .wdata   (r_wb.data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (w_rf_a),
    .rdata_b (w_rf_b)
  );

  // The uncommitted WB entry is newer than anything in the rf.
  assign rd_data_a = (r_wb.valid && r_wb.we && (r_wb.addr == rd_addr_a)) ? r_wb.data : w_rf_a;
  assign rd_data_b = (r_wb.valid && r_wb.we && (r_wb.addr == rd_addr_b)) ? r_wb.data : w_rf_b;
  assign flag_fwd  = (r_wb.valid && r_wb.fe) ? r_wb.flag : r_flag;
  assign flag_q      = r_flag;
  assign retired_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// ============================================================================
// tb_alu_writeback : directed + random checks against a queue-based model
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_writeback;

  typedef struct {
    bit       we;
    bit       fe;
    bit [3:0] addr;
    bit [7:0] data;
    bit       flag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  alu_out = '0;
  logic        alu_flag = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic        flag_en = 1'b0;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        flag_fwd;
  logic        flag_q;
  logic [15:0] retired_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: architectural state plus in-flight results in order
  bit [7:0]  m_rf [16];
  bit        m_flag;
  bit [15:0] m_cnt;
  ent_t      m_pend [$];

  alu_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_out     (alu_out),
    .alu_flag    (alu_flag),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flag_en     (flag_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .flag_fwd    (flag_fwd),
    .flag_q      (flag_q),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [7:0] m_read(input bit [3:0] a);
    foreach (m_pend[i]) begin
      if (m_pend[i].we && m_pend[i].addr == a) return m_pend[i].data;
    end
    return m_rf[a];
  endfunction

  function automatic bit m_fwd();
    foreach (m_pend[i]) begin
      if (m_pend[i].fe) return m_pend[i].flag;
    end
    return m_flag;
  endfunction

  task automatic m_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_flag = 1'b0;
    m_cnt  = '0;
    m_pend.delete();
  endtask

  // one clock: check outputs mid-cycle, advance model, return just after the edge
  task automatic step(input bit do_check);
    ent_t e;
    @(negedge clk);
    #1;
    if (do_check) begin
      chk("in_ready", in_ready, !stall);
      chk("rd_a", rd_data_a, m_read(rd_addr_a));
      chk("rd_b", rd_data_b, m_read(rd_addr_b));
      chk("flag_fwd", flag_fwd, m_fwd());
      chk("flag_q", flag_q, m_flag);
      chk("cnt", retired_cnt, m_cnt);
    end
    if (!stall) begin
      if (m_pend.size() != 0) begin
        e = m_pend.pop_front();
        if (e.we) m_rf[e.addr] = e.data;
        if (e.fe) m_flag = e.flag;
        m_cnt = m_cnt + 16'd1;
      end
      if (in_valid) begin
        e.we = wr_en; e.fe = flag_en; e.addr = wr_addr; e.data = alu_out; e.flag = alu_flag;
        m_pend.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input bit [3:0] a, input bit [7:0] d,
                       input bit fe, input bit f);
    in_valid = v; wr_en = we; wr_addr = a; alu_out = d; flag_en = fe; alu_flag = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cs;
    m_reset();
    do_reset();

    // reset state over every address
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      step(1);
      chk("rst_rd_a", rd_data_a, 8'h00);
      chk("rst_rd_b", rd_data_b, 8'h00);
    end
    chk("rst_fwd", flag_fwd, 1'b0);
    chk("rst_cnt", retired_cnt, 16'h0000);

    // basic write then bypass then commit
    rd_addr_a = 4'd3; rd_addr_b = 4'd4;
    drive(1, 1, 3, 8'h5A, 0, 0);
    step(1);
    chk("basic_byp", rd_data_a, 8'h5A);
    drive(0, 0, 0, 0, 0, 0);
    step(1);
    chk("basic_commit", rd_data_a, 8'h5A);
    chk("basic_cnt", retired_cnt, 16'd1);

    // back-to-back same register
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    drive(1, 1, 7, 8'h11, 0, 0);
    step(1);
    chk("b2b_e1_a", rd_data_a, 8'h11);
    chk("b2b_e1_b", rd_data_b, 8'h11);
    drive(1, 1, 7, 8'h22, 0, 0);
    step(1);
    chk("b2b_e2_a", rd_data_a, 8'h22);
    chk("b2b_e2_b", rd_data_b, 8'h22);
    drive(0, 0, 0, 0, 0, 0);
    step(1);
    chk("b2b_e3", rd_data_a, 8'h22);
    step(1);

    // flag path
    rd_addr_a = 4'd5;
    drive(1, 0, 5, 8'hC3, 1, 1);
    step(1);
    chk("flag_fwd_e1", flag_fwd, 1'b1);
    chk("flag_q_e1", flag_q, 1'b0);
    drive(1, 0, 5, 8'h3C, 0, 0);
    step(1);
    chk("flag_q_e2", flag_q, 1'b1);
    chk("flag_norf", rd_data_a, 8'h00);
    drive(0, 0, 0, 0, 0, 0);
    step(1);
    chk("flag_hold", flag_q, 1'b1);

    // stall holds the WB entry and all state
    rd_addr_a = 4'd2;
    drive(1, 1, 2, 8'h80, 0, 0);
    step(1);
    cs = retired_cnt;
    stall = 1'b1;
    drive(1, 1, 2, 8'hFF, 0, 0);
    repeat (3) begin
      step(1);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_byp", rd_data_a, 8'h80);
      chk("stall_cnt", retired_cnt, 16'(cs));
    end
    stall = 1'b0;
    step(1);
    chk("unstall_cnt", retired_cnt, 16'(cs + 1));
    chk("unstall_byp", rd_data_a, 8'hFF);
    drive(0, 0, 0, 0, 0, 0);
    step(1);

    // randomized traffic, addresses biased low to exercise bypass
    for (int n = 0; n < 400; n++) begin
      stall     = ($urandom_range(3) == 0);
      rd_addr_a = ($urandom_range(1) == 1) ? 4'($urandom_range(3)) : 4'($urandom);
      rd_addr_b = ($urandom_range(1) == 1) ? 4'($urandom_range(3)) : 4'($urandom);
      drive($urandom_range(3) != 0, $urandom_range(1) == 1,
            ($urandom_range(1) == 1) ? 4'($urandom_range(3)) : 4'($urandom),
            8'($urandom), $urandom_range(1) == 1, $urandom_range(1) == 1);
      step(1);
    end
    stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(1);

    // counter wrap
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    while (m_cnt != 16'hFFFF) step(0);
    chk("cnt_ffff", retired_cnt, 16'hFFFF);
    chk("cnt_ffff_m", retired_cnt, m_cnt);
    drive(0, 0, 0, 0, 0, 0);
    step(1);
    chk("cnt_wrap", retired_cnt, 16'h0000);

    // reset with a pending write in WB
    rd_addr_a = 4'd9; rd_addr_b = 4'd9;
    drive(1, 1, 9, 8'h77, 1, 1);
    step(1);
    chk("pend_byp", rd_data_a, 8'h77);
    do_reset();
    chk("rst_drop_a", rd_data_a, 8'h00);
    chk("rst_drop_fwd", flag_fwd, 1'b0);
    step(1);
    step(1);
    chk("rst_drop_rf", rd_data_b, 8'h00);
    chk("rst_drop_cnt", retired_cnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
